mult_fu: RTL and testbench

Pipelined integer multiply functional unit sitting directly downstream of the reservation station. It accepts one issued multiply packet per cycle from an RS mult-select slot, and computes the RV32M product over `STAGES` cycles. It presents the result as a CDB request and holds it until granted. Its `avail` output drives the RS `fu_mult_avail` bit for this unit.

---
 rtl/mult_fu_if.sv | 30 +++
 rtl/mult_fu.sv | 119 +++++++++++
 tb/tb_mult_fu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_fu_if.sv
// Issue and CDB bundle shared by the reservation station, mult_fu and the CDB arbiter.
// The master side drives issue packets and the CDB grant; the slave side is the unit.
interface mult_fu_if #(
    parameter int XLEN          = 32,
    parameter int PRN_WIDTH     = 6,
    parameter int ROB_CNT_WIDTH = 5
);
    logic                     fu_valid;
    logic [1:0]               fu_func;
    logic [XLEN-1:0]          fu_rs1;
    logic [XLEN-1:0]          fu_rs2;
    logic [PRN_WIDTH-1:0]     fu_dest_prn;
    logic [ROB_CNT_WIDTH-1:0] fu_robn;
    logic                     avail;
    logic                     cdb_grant;
    logic                     out_valid;
    logic [XLEN-1:0]          out_value;
    logic [PRN_WIDTH-1:0]     out_dest_prn;
    logic [ROB_CNT_WIDTH-1:0] out_robn;

    modport master (
        output fu_valid, fu_func, fu_rs1, fu_rs2, fu_dest_prn, fu_robn, cdb_grant,
        input  avail, out_valid, out_value, out_dest_prn, out_robn
    );

    modport slave (
        input  fu_valid, fu_func, fu_rs1, fu_rs2, fu_dest_prn, fu_robn, cdb_grant,
        output avail, out_valid, out_value, out_dest_prn, out_robn
    );
endinterface

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: STAGES-deep elastic pipeline holding its result as a CDB request.
// Optional macro MULT_SQUASH_EN adds a squash input that flushes every in-flight op.
module mult_fu #(
    parameter int STAGES        = 4,
    parameter int XLEN          = 32,
    parameter int PRN_WIDTH     = 6,
    parameter int ROB_CNT_WIDTH = 5
) (
    input logic      clock,
    input logic      reset,
`ifdef MULT_SQUASH_EN
    input logic      squash,
`endif
    mult_fu_if.slave fu
);
    localparam int PW    = 2 * XLEN;
    localparam int CHUNK = PW / STAGES;
    localparam int LAST  = STAGES - 1;

    localparam logic [1:0] FUNC_MUL    = 2'd0;
    localparam logic [1:0] FUNC_MULH   = 2'd1;
    localparam logic [1:0] FUNC_MULHSU = 2'd2;

    logic [STAGES-1:0]        vld_p;
    logic [1:0]               func_p   [STAGES];
    logic [PW-1:0]            mcand_p  [STAGES];
    logic [PW-1:0]            mplier_p [STAGES];
    logic [PW-1:0]            psum_p   [STAGES];
    logic [PRN_WIDTH-1:0]     prn_p    [STAGES];
    logic [ROB_CNT_WIDTH-1:0] robn_p   [STAGES];

    logic [STAGES-1:0] ready;
    logic              flush;
    logic              accept;
    logic [PW-1:0]     mcand_in;
    logic [PW-1:0]     mplier_in;

    function automatic logic [PW-1:0] extend(input logic [XLEN-1:0] v, input logic sgn);
        return {{XLEN{sgn & v[XLEN-1]}}, v};
    endfunction

    // One multiplier digit per stage; everything is modulo 2^64, so signedness lives only in extension.
    function automatic logic [PW-1:0] accumulate(input logic [PW-1:0] psum,
                                                 input logic [PW-1:0] mcand,
                                                 input logic [PW-1:0] mplier);
        logic [PW-1:0] digit;
        digit = PW'(mplier[CHUNK-1:0]);
        return psum + mcand * digit;
    endfunction

`ifdef MULT_SQUASH_EN
    assign flush = squash;
`else
    assign flush = 1'b0;
`endif

    // A stage can load when it is empty or its occupant moves on; the chain starts at the CDB grant.
    always_comb begin
        ready       = '0;
        ready[LAST] = !vld_p[LAST] || fu.cdb_grant;
        for (int s = LAST - 1; s >= 0; s--) begin
            ready[s] = !vld_p[s] || ready[s+1];
        end
    end

    assign fu.avail  = ready[0];
    assign accept    = fu.fu_valid && ready[0];
    assign mcand_in  = extend(fu.fu_rs1, (fu.fu_func == FUNC_MULH) || (fu.fu_func == FUNC_MULHSU));
    assign mplier_in = extend(fu.fu_rs2, fu.fu_func == FUNC_MULH);

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p <= '0;
            for (int s = 0; s < STAGES; s++) begin
                func_p[s]   <= '0;
                mcand_p[s]  <= '0;
                mplier_p[s] <= '0;
                psum_p[s]   <= '0;
                prn_p[s]    <= '0;
                robn_p[s]   <= '0;
            end
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            // stage s-1 -> stage s boundary
            for (int s = 1; s < STAGES; s++) begin
                if (ready[s]) begin
                    vld_p[s] <= vld_p[s-1];
                    if (vld_p[s-1]) begin
                        func_p[s]   <= func_p[s-1];
                        mcand_p[s]  <= mcand_p[s-1] << CHUNK;
                        mplier_p[s] <= mplier_p[s-1] >> CHUNK;
                        psum_p[s]   <= accumulate(psum_p[s-1], mcand_p[s-1], mplier_p[s-1]);
                        prn_p[s]    <= prn_p[s-1];
                        robn_p[s]   <= robn_p[s-1];
                    end
                end
            end
            // issue -> stage 0 boundary
            if (ready[0]) begin
                vld_p[0] <= accept;
                if (accept) begin
                    func_p[0]   <= fu.fu_func;
                    mcand_p[0]  <= mcand_in << CHUNK;
                    mplier_p[0] <= mplier_in >> CHUNK;
                    psum_p[0]   <= accumulate('0, mcand_in, mplier_in);
                    prn_p[0]    <= fu.fu_dest_prn;
                    robn_p[0]   <= fu.fu_robn;
                end
            end
        end
    end

    assign fu.out_valid    = vld_p[LAST];
    assign fu.out_value    = (func_p[LAST] == FUNC_MUL) ? psum_p[LAST][XLEN-1:0]
                                                        : psum_p[LAST][PW-1:XLEN];
    assign fu.out_dest_prn = prn_p[LAST];
    assign fu.out_robn     = robn_p[LAST];
endmodule

// File: tb/tb_mult_fu.sv
// Directed and randomized bench for mult_fu against an in-order queue model with 64-bit reference products.
module tb_mult_fu;
    localparam int S     = 4;
    localparam int PRN_W = 6;
    localparam int ROB_W = 5;

    typedef struct {
        logic [1:0]       func;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [PRN_W-1:0] prn;
        logic [ROB_W-1:0] robn;
        int               acc;
    } op_t;

    logic clock;
    logic reset;
`ifdef MULT_SQUASH_EN
    logic squash;
`endif

    mult_fu_if #(.XLEN(32), .PRN_WIDTH(PRN_W), .ROB_CNT_WIDTH(ROB_W)) bus ();

    mult_fu #(.STAGES(S), .XLEN(32), .PRN_WIDTH(PRN_W), .ROB_CNT_WIDTH(ROB_W)) dut (
        .clock (clock),
        .reset (reset),
`ifdef MULT_SQUASH_EN
        .squash(squash),
`endif
        .fu    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          last_retire = 0;
    int          retired_cnt = 0;
    op_t         q[$];
    logic [31:0] retired_vals[$];

    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        case (f)
            2'd0: return a * b;
            2'd1: begin sp = longint'(signed'(a)) * longint'(signed'(b)); return sp[63:32]; end
            2'd2: begin sp = longint'(signed'(a)) * longint'(b);          return sp[63:32]; end
            default: begin up = longint'(a) * longint'(b);               return up[63:32]; end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check against the model, step the edge, update the model.
    task automatic cycle(input logic v, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [PRN_W-1:0] prn,
                         input logic [ROB_W-1:0] robn, input logic g);
        logic        exp_avail;
        logic        exp_ov;
        logic        obs_ov;
        logic [31:0] obs_val;
        int          arrive;
        op_t         o;
        bus.fu_valid    = v;
        bus.fu_func     = f;
        bus.fu_rs1      = a;
        bus.fu_rs2      = b;
        bus.fu_dest_prn = prn;
        bus.fu_robn     = robn;
        bus.cdb_grant   = g;
        #1;
        exp_avail = (q.size() < S) || g;
        exp_ov    = 1'b0;
        if (q.size() > 0) begin
            arrive = q[0].acc + S - 1;
            if (last_retire > arrive) arrive = last_retire;
            exp_ov = (edge_cnt >= arrive);
        end
        obs_ov  = bus.out_valid;
        obs_val = bus.out_value;
        chk("avail", 64'(bus.avail), 64'(exp_avail));
        chk("out_valid", 64'(obs_ov), 64'(exp_ov));
        if (exp_ov && obs_ov) begin
            chk("out_value", 64'(obs_val), 64'(ref_result(q[0].func, q[0].a, q[0].b)));
            chk("out_dest_prn", 64'(bus.out_dest_prn), 64'(q[0].prn));
            chk("out_robn", 64'(bus.out_robn), 64'(q[0].robn));
        end
        @(posedge clock);
        edge_cnt++;
        if (obs_ov && g) begin
            retired_cnt++;
            retired_vals.push_back(obs_val);
        end
        if (exp_ov && g) begin
            void'(q.pop_front());
            last_retire = edge_cnt;
        end
        if (v && exp_avail) begin
            o.func = f; o.a = a; o.b = b; o.prn = prn; o.robn = robn; o.acc = edge_cnt;
            q.push_back(o);
        end
        #1;
    endtask

    task automatic idle(input int n, input logic g);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 32'd0, '0, '0, g);
    endtask

    task automatic rand_op(input logic g);
        cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom,
              PRN_W'($urandom), ROB_W'($urandom), g);
    endtask

    task automatic do_reset();
        bus.fu_valid  = 1'b1;
        bus.fu_rs1    = $urandom;
        bus.fu_rs2    = $urandom;
        bus.cdb_grant = 1'b0;
        reset         = 1'b1;
        repeat (2) begin
            @(posedge clock);
            edge_cnt++;
        end
        #1;
        reset        = 1'b0;
        bus.fu_valid = 1'b0;
        q.delete();
        last_retire  = edge_cnt;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_avail", 64'(bus.avail), 64'd1);
        chk("rst_out_value", 64'(bus.out_value), 64'd0);
        chk("rst_prn", 64'(bus.out_dest_prn), 64'd0);
        chk("rst_robn", 64'(bus.out_robn), 64'd0);
    endtask

`ifdef MULT_SQUASH_EN
    task automatic do_squash();
        squash        = 1'b1;
        bus.fu_valid  = 1'b1;
        bus.cdb_grant = 1'b1;
        @(posedge clock);
        edge_cnt++;
        q.delete();
        last_retire = edge_cnt;
        #1;
        squash        = 1'b0;
        bus.fu_valid  = 1'b0;
        bus.cdb_grant = 1'b0;
        #1;
        chk("sq_out_valid", 64'(bus.out_valid), 64'd0);
        chk("sq_avail", 64'(bus.avail), 64'd1);
    endtask
`endif

    initial begin
        int          base;
        logic [31:0] pick [6];
        reset           = 1'b1;
`ifdef MULT_SQUASH_EN
        squash          = 1'b0;
`endif
        bus.fu_valid    = 1'b0;
        bus.fu_func     = 2'd0;
        bus.fu_rs1      = '0;
        bus.fu_rs2      = '0;
        bus.fu_dest_prn = '0;
        bus.fu_robn     = '0;
        bus.cdb_grant   = 1'b0;
        do_reset();

        // single MUL with grant tied high
        retired_vals.delete();
        cycle(1'b1, 2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 6'd5, 5'd3, 1'b1);
        idle(S + 2, 1'b1);
        chk("mul_count", 64'(retired_vals.size()), 64'd1);
        if (retired_vals.size() > 0) chk("mul_value", 64'(retired_vals[0]), 64'hFFFF_FFEB);

        // high-half variants
        retired_vals.delete();
        cycle(1'b1, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd1, 5'd1, 1'b1);
        cycle(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2, 5'd2, 1'b1);
        cycle(1'b1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3, 5'd3, 1'b1);
        idle(S + 2, 1'b1);
        chk("high_count", 64'(retired_vals.size()), 64'd3);
        if (retired_vals.size() == 3) begin
            chk("mulh", 64'(retired_vals[0]), 64'h0000_0000);
            chk("mulhsu", 64'(retired_vals[1]), 64'h8000_0000);
            chk("mulhu", 64'(retired_vals[2]), 64'h7FFF_FFFF);
        end

        // back-to-back issue into a stalled CDB, then drain
        base = retired_cnt;
        for (int i = 0; i < 6; i++) rand_op(1'b0);
        chk("stall_avail", 64'(bus.avail), 64'd0);
        idle(S + 3, 1'b1);
        chk("stall_drain_count", 64'(retired_cnt - base), 64'(S));

        // same-edge accept and retire on a full pipeline
        for (int i = 0; i < S; i++) rand_op(1'b0);
        rand_op(1'b1);
        rand_op(1'b0);
        idle(S + 3, 1'b1);

        // randomized traffic with corner operands
        pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'hFFFF_FFFF;
        pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF; pick[5] = 32'h0;
        for (int i = 0; i < 400; i++) begin
            pick[5] = $urandom;
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  pick[$urandom_range(0, 5)], pick[$urandom_range(0, 5)],
                  PRN_W'($urandom), ROB_W'($urandom), $urandom_range(0, 2) != 0);
        end
        idle(S + 3, 1'b1);

`ifdef MULT_SQUASH_EN
        for (int i = 0; i < 3; i++) rand_op(1'b0);
        do_squash();
        idle(S + 2, 1'b1);
`endif
        // reset mid-flight
        for (int i = 0; i < 3; i++) rand_op(1'b0);
        do_reset();
        idle(S + 2, 1'b1);
        rand_op(1'b1);
        idle(S + 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
